// File: rtl/mul_issue_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mul_issue_ctrl_pkg
//   Shared definitions for the Ex-side multiply initiator:
//   - bus widths (DataBus, RegFileAddr, MulDataBus)
//   - hold-flag encodings driven towards the multiplier
//   - FSM state encoding
//   - OP / OP-32 opcodes and the M-extension multiply funct3 codes
//   - helper that tells whether a funct3 selects the high product half
// ---------------------------------------------------------------------------
package mul_issue_ctrl_pkg;

    localparam int DataBus     = 64;
    localparam int RegFileAddr = 5;
    localparam int MulDataBus  = 128;

    localparam logic [1:0] MulHoldIdle  = 2'b00;
    localparam logic [1:0] MulHoldStart = 2'b01;
    localparam logic [1:0] MulHoldBusy  = 2'b10;

    localparam logic [6:0] OpcodeOp   = 7'b0110011;
    localparam logic [6:0] OpcodeOp32 = 7'b0111011;

    localparam logic [2:0] Funct3Mul    = 3'b000;
    localparam logic [2:0] Funct3Mulh   = 3'b001;
    localparam logic [2:0] Funct3Mulhsu = 3'b010;
    localparam logic [2:0] Funct3Mulhu  = 3'b011;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_DRAIN = 3'd4
    } mul_state_e;

    // MULH, MULHSU and MULHU all return the upper 64 bits of the product.
    function automatic logic is_high_half(input logic [2:0] funct3);
        return (funct3 == Funct3Mulh) ||
               (funct3 == Funct3Mulhsu) ||
               (funct3 == Funct3Mulhu);
    endfunction

endpackage

// File: rtl/mul_result_sel.sv
// ---------------------------------------------------------------------------
// mul_result_sel
//   Combinational result selection from the 128-bit multiplier product.
//   Ports:
//     product  in  128  raw product from the multiplier
//     opcode   in  7    instruction opcode (OP or OP-32)
//     funct3   in  3    multiply variant
//     result   out 64   value to write back
//   MULW returns the sign-extended low word; MUL the low doubleword;
//   MULH/MULHSU/MULHU the high doubleword. Operand signedness is already
//   resolved inside the multiplier, so no correction is applied here.
// ---------------------------------------------------------------------------
module mul_result_sel
    import mul_issue_ctrl_pkg::*;
(
    input  logic [MulDataBus-1:0] product,
    input  logic [6:0]            opcode,
    input  logic [2:0]            funct3,
    output logic [DataBus-1:0]    result
);

    always_comb begin
        result = product[DataBus-1:0];
        if (opcode == OpcodeOp32) begin
            result = {{32{product[31]}}, product[31:0]};
        end else if (is_high_half(funct3)) begin
            result = product[MulDataBus-1:DataBus];
        end
    end

endmodule

// File: rtl/mul_issue_ctrl.sv
// ---------------------------------------------------------------------------
// mul_issue_ctrl
//   Ex-side initiator for the multi-cycle multiplier. Accepts one multiply
//   from Ex, runs the start/busy hold-flag handshake, stalls the pipeline
//   while the multiply is outstanding and presents a one-cycle write-back.
//   Flushes and a multiplier that never answers are both absorbed.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | no multiply outstanding; accepts a request from Ex
//   ISSUE | hold=01 for one cycle; multiplier latches the operands
//   WAIT  | hold=10; waiting for end, result kept on end
//   DRAIN | hold=10; flushed multiply still running, result discarded
//   DONE  | one-cycle write-back, stall released
//
//   Ports:
//     Clk, Rst                  clock, async active-low reset
//     MulReqValid, MulRs1Data, MulRs2Data, MulRdAddr,
//     MulOpCode, MulFunct3, MulFunct7      request from Ex
//     Flush                     squash in-flight or requested multiply
//     MulHoldFlagToMul          00 idle / 01 start / 10 busy
//     Mulitiplicand/MulitiplierToMul, MulWriteAddrToMul, MulOpCodeToMul,
//     MulFunct3ToMul, MulFunct7ToMul      registered request fields
//     ProductFromMul, MulHoldEndFromMul   multiplier response
//     MulStallToCtrl            pipeline hold
//     WbValid, WbWriteEn, WbAddr, WbData  write-back
//     MulTimeout                sticky watchdog error
// ---------------------------------------------------------------------------
module mul_issue_ctrl
    import mul_issue_ctrl_pkg::*;
#(
    parameter int TimeoutCycles = 64
) (
    input  logic                   Clk,
    input  logic                   Rst,

    input  logic                   MulReqValid,
    input  logic [DataBus-1:0]     MulRs1Data,
    input  logic [DataBus-1:0]     MulRs2Data,
    input  logic [RegFileAddr-1:0] MulRdAddr,
    input  logic [6:0]             MulOpCode,
    input  logic [2:0]             MulFunct3,
    input  logic [6:0]             MulFunct7,
    input  logic                   Flush,

    output logic [1:0]             MulHoldFlagToMul,
    output logic [DataBus-1:0]     MulitiplicandToMul,
    output logic [DataBus-1:0]     MulitiplierToMul,
    output logic [RegFileAddr-1:0] MulWriteAddrToMul,
    output logic [6:0]             MulOpCodeToMul,
    output logic [2:0]             MulFunct3ToMul,
    output logic [6:0]             MulFunct7ToMul,

    input  logic [MulDataBus-1:0]  ProductFromMul,
    input  logic                   MulHoldEndFromMul,

    output logic                   MulStallToCtrl,

    output logic                   WbValid,
    output logic                   WbWriteEn,
    output logic [RegFileAddr-1:0] WbAddr,
    output logic [DataBus-1:0]     WbData,

    output logic                   MulTimeout
);

    localparam logic [7:0] WdLast = 8'(TimeoutCycles - 1);

    mul_state_e          state;
    logic [7:0]          wd_cnt;
    logic [DataBus-1:0]  sel_result;

    // Selection uses the registered fields: the Ex inputs may already carry
    // the next instruction while this one is in flight.
    mul_result_sel u_result_sel (
        .product (ProductFromMul),
        .opcode  (MulOpCodeToMul),
        .funct3  (MulFunct3ToMul),
        .result  (sel_result)
    );

    // The IDLE term is combinational so Ex is held in the very cycle the
    // request is accepted; the stall drops in DONE so Ex advances during
    // the write-back cycle.
    assign MulStallToCtrl = ((state != S_IDLE) && (state != S_DONE)) ||
                            ((state == S_IDLE) && MulReqValid && !Flush);

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state              <= S_IDLE;
            wd_cnt             <= '0;
            MulHoldFlagToMul   <= MulHoldIdle;
            MulitiplicandToMul <= '0;
            MulitiplierToMul   <= '0;
            MulWriteAddrToMul  <= '0;
            MulOpCodeToMul     <= '0;
            MulFunct3ToMul     <= '0;
            MulFunct7ToMul     <= '0;
            WbValid            <= 1'b0;
            WbWriteEn          <= 1'b0;
            WbAddr             <= '0;
            WbData             <= '0;
            MulTimeout         <= 1'b0;
        end else begin
            WbValid   <= 1'b0;
            WbWriteEn <= 1'b0;

            unique case (state)
                S_IDLE: begin
                    if (MulReqValid && !Flush) begin
                        MulitiplicandToMul <= MulRs1Data;
                        MulitiplierToMul   <= MulRs2Data;
                        MulWriteAddrToMul  <= MulRdAddr;
                        MulOpCodeToMul     <= MulOpCode;
                        MulFunct3ToMul     <= MulFunct3;
                        MulFunct7ToMul     <= MulFunct7;
                        MulHoldFlagToMul   <= MulHoldStart;
                        state              <= S_ISSUE;
                    end
                end

                // The multiplier has already seen start, so a flush here
                // cannot cancel it; DRAIN waits for its end instead. An end
                // during ISSUE is a protocol violation and is ignored.
                S_ISSUE: begin
                    wd_cnt           <= '0;
                    MulHoldFlagToMul <= MulHoldBusy;
                    state            <= Flush ? S_DRAIN : S_WAIT;
                end

                S_WAIT: begin
                    if (MulHoldEndFromMul) begin
                        MulHoldFlagToMul <= MulHoldIdle;
                        if (Flush) begin
                            state <= S_IDLE;
                        end else begin
                            WbValid   <= 1'b1;
                            WbWriteEn <= (MulWriteAddrToMul != '0);
                            WbAddr    <= MulWriteAddrToMul;
                            WbData    <= sel_result;
                            state     <= S_DONE;
                        end
                    end else if (wd_cnt == WdLast) begin
                        MulTimeout       <= 1'b1;
                        MulHoldFlagToMul <= MulHoldIdle;
                        state            <= S_IDLE;
                    end else begin
                        // The watchdog keeps running across WAIT->DRAIN so a
                        // flushed multiply cannot extend the budget.
                        wd_cnt <= wd_cnt + 8'd1;
                        if (Flush) begin
                            state <= S_DRAIN;
                        end
                    end
                end

                S_DRAIN: begin
                    if (MulHoldEndFromMul) begin
                        MulHoldFlagToMul <= MulHoldIdle;
                        state            <= S_IDLE;
                    end else if (wd_cnt == WdLast) begin
                        MulTimeout       <= 1'b1;
                        MulHoldFlagToMul <= MulHoldIdle;
                        state            <= S_IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 8'd1;
                    end
                end

                // The instruction has retired; a flush here has nothing left
                // to squash.
                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    MulHoldFlagToMul <= MulHoldIdle;
                    state            <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
module tb_mul_issue_ctrl;

    logic          Clk;
    logic          Rst;
    logic          MulReqValid;
    logic [63:0]   MulRs1Data;
    logic [63:0]   MulRs2Data;
    logic [4:0]    MulRdAddr;
    logic [6:0]    MulOpCode;
    logic [2:0]    MulFunct3;
    logic [6:0]    MulFunct7;
    logic          Flush;
    logic [1:0]    MulHoldFlagToMul;
    logic [63:0]   MulitiplicandToMul;
    logic [63:0]   MulitiplierToMul;
    logic [4:0]    MulWriteAddrToMul;
    logic [6:0]    MulOpCodeToMul;
    logic [2:0]    MulFunct3ToMul;
    logic [6:0]    MulFunct7ToMul;
    logic [127:0]  ProductFromMul;
    logic          MulHoldEndFromMul;
    logic          MulStallToCtrl;
    logic          WbValid;
    logic          WbWriteEn;
    logic [4:0]    WbAddr;
    logic [63:0]   WbData;
    logic          MulTimeout;

    mul_issue_ctrl #(.TimeoutCycles(64)) dut (
        .Clk                (Clk),
        .Rst                (Rst),
        .MulReqValid        (MulReqValid),
        .MulRs1Data         (MulRs1Data),
        .MulRs2Data         (MulRs2Data),
        .MulRdAddr          (MulRdAddr),
        .MulOpCode          (MulOpCode),
        .MulFunct3          (MulFunct3),
        .MulFunct7          (MulFunct7),
        .Flush              (Flush),
        .MulHoldFlagToMul   (MulHoldFlagToMul),
        .MulitiplicandToMul (MulitiplicandToMul),
        .MulitiplierToMul   (MulitiplierToMul),
        .MulWriteAddrToMul  (MulWriteAddrToMul),
        .MulOpCodeToMul     (MulOpCodeToMul),
        .MulFunct3ToMul     (MulFunct3ToMul),
        .MulFunct7ToMul     (MulFunct7ToMul),
        .ProductFromMul     (ProductFromMul),
        .MulHoldEndFromMul  (MulHoldEndFromMul),
        .MulStallToCtrl     (MulStallToCtrl),
        .WbValid            (WbValid),
        .WbWriteEn          (WbWriteEn),
        .WbAddr             (WbAddr),
        .WbData             (WbData),
        .MulTimeout         (MulTimeout)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    localparam logic [6:0] OP   = 7'b0110011;
    localparam logic [6:0] OP32 = 7'b0111011;
    localparam logic [6:0] F7M  = 7'b0000001;

    typedef struct {
        logic [63:0]  rs1;
        logic [63:0]  rs2;
        logic [4:0]   rd;
        logic [6:0]   opcode;
        logic [2:0]   funct3;
        logic [127:0] product;
        int           lat;
        logic [63:0]  exp_data;
        logic         exp_we;
    } vec_t;

    vec_t vecs[7];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic present_req(input logic [63:0] rs1, input logic [63:0] rs2,
                               input logic [4:0] rd, input logic [6:0] opc,
                               input logic [2:0] f3);
        MulReqValid = 1'b1;
        MulRs1Data  = rs1;
        MulRs2Data  = rs2;
        MulRdAddr   = rd;
        MulOpCode   = opc;
        MulFunct3   = f3;
        MulFunct7   = F7M;
    endtask

    // One full multiply with a multiplier answering after v.lat busy cycles.
    task automatic run_op(input int i);
        vec_t v;
        v = vecs[i];
        next_cycle();
        present_req(v.rs1, v.rs2, v.rd, v.opcode, v.funct3);
        @(negedge Clk);
        check($sformatf("v%0d stall_req", i), MulStallToCtrl, 1'b1);
        check($sformatf("v%0d wb_in_req", i), WbValid, 1'b0);
        next_cycle();
        MulReqValid = 1'b0;
        MulRs1Data  = ~v.rs1;
        MulRs2Data  = ~v.rs2;
        MulRdAddr   = ~v.rd;
        @(negedge Clk);
        check($sformatf("v%0d hold_start", i), MulHoldFlagToMul, 2'b01);
        check($sformatf("v%0d rs1_out", i), MulitiplicandToMul, v.rs1);
        check($sformatf("v%0d rs2_out", i), MulitiplierToMul, v.rs2);
        check($sformatf("v%0d rd_out", i), MulWriteAddrToMul, v.rd);
        check($sformatf("v%0d opc_out", i), {MulOpCodeToMul, MulFunct3ToMul, MulFunct7ToMul},
              {v.opcode, v.funct3, F7M});
        for (int k = 0; k < v.lat; k++) begin
            next_cycle();
            if (k == v.lat - 1) begin
                MulHoldEndFromMul = 1'b1;
                ProductFromMul    = v.product;
            end
            @(negedge Clk);
            check($sformatf("v%0d hold_busy%0d", i, k), MulHoldFlagToMul, 2'b10);
            check($sformatf("v%0d stall_wait%0d", i, k), MulStallToCtrl, 1'b1);
            check($sformatf("v%0d rs1_stable%0d", i, k), MulitiplicandToMul, v.rs1);
        end
        next_cycle();
        MulHoldEndFromMul = 1'b0;
        ProductFromMul    = '0;
        @(negedge Clk);
        check($sformatf("v%0d wb_valid", i), WbValid, 1'b1);
        check($sformatf("v%0d wb_we", i), WbWriteEn, v.exp_we);
        check($sformatf("v%0d wb_addr", i), WbAddr, v.rd);
        check($sformatf("v%0d wb_data", i), WbData, v.exp_data);
        check($sformatf("v%0d stall_done", i), MulStallToCtrl, 1'b0);
        check($sformatf("v%0d hold_done", i), MulHoldFlagToMul, 2'b00);
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, " hold"}, MulHoldFlagToMul, 2'b00);
        check({nm, " ops"}, {MulitiplicandToMul, MulitiplierToMul}, 128'd0);
        check({nm, " fields"}, {MulWriteAddrToMul, MulOpCodeToMul, MulFunct3ToMul, MulFunct7ToMul}, 22'd0);
        check({nm, " stall"}, MulStallToCtrl, 1'b0);
        check({nm, " wb"}, {WbValid, WbWriteEn, WbAddr}, 7'd0);
        check({nm, " wb_data"}, WbData, 64'd0);
        check({nm, " timeout"}, MulTimeout, 1'b0);
    endtask

    initial begin
        //            rs1            rs2          rd     opc   f3      product                                   lat exp_data                 we
        vecs[0] = '{64'd3,         64'd7,        5'd5,  OP,   3'b000, 128'd21,                                   4, 64'd21,                  1'b1};
        vecs[1] = '{64'h8000_0000, 64'd1,        5'd7,  OP32, 3'b000, 128'h0000_0000_0000_0000_0000_0000_8000_0000, 3, 64'hFFFF_FFFF_8000_0000, 1'b1};
        vecs[2] = '{64'hFFFF,      64'h1_0001,   5'd10, OP,   3'b011, 128'h0000_0000_0000_0001_0000_0000_0000_0000, 2, 64'd1,                   1'b1};
        vecs[3] = '{64'd1,         64'd5,        5'd0,  OP,   3'b000, 128'd5,                                    4, 64'd5,                   1'b0};
        vecs[4] = '{64'h1234,      64'h5678,     5'd31, OP,   3'b001, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0000_1111, 1, 64'hDEAD_BEEF_0123_4567, 1'b1};
        vecs[5] = '{64'h55,        64'hAA,       5'd12, OP,   3'b010, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0002, 5, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1};
        vecs[6] = '{64'h77,        64'h99,       5'd20, OP32, 3'b000, 128'hAAAA_BBBB_CCCC_DDDD_1234_5678_7FFF_FFFF, 2, 64'h0000_0000_7FFF_FFFF, 1'b1};

        Rst = 1'b0;
        MulReqValid = 1'b0;
        MulRs1Data = '0;
        MulRs2Data = '0;
        MulRdAddr = '0;
        MulOpCode = '0;
        MulFunct3 = '0;
        MulFunct7 = '0;
        Flush = 1'b0;
        ProductFromMul = '0;
        MulHoldEndFromMul = 1'b0;
        #3;
        check_all_zero("reset");
        repeat (2) @(posedge Clk);
        #2;
        Rst = 1'b1;

        for (int i = 0; i < 7; i++) run_op(i);

        // Flush during ISSUE: multiplier ends three cycles later, result dropped.
        next_cycle();
        present_req(64'd4, 64'd5, 5'd3, OP, 3'b000);
        next_cycle();
        MulReqValid = 1'b0;
        Flush = 1'b1;
        @(negedge Clk);
        check("fi hold_start", MulHoldFlagToMul, 2'b01);
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            Flush = 1'b0;
            if (k == 2) begin
                MulHoldEndFromMul = 1'b1;
                ProductFromMul = 128'd20;
            end
            @(negedge Clk);
            check($sformatf("fi drain_hold%0d", k), MulHoldFlagToMul, 2'b10);
            check($sformatf("fi drain_stall%0d", k), MulStallToCtrl, 1'b1);
            check($sformatf("fi drain_wb%0d", k), WbValid, 1'b0);
        end
        next_cycle();
        MulHoldEndFromMul = 1'b0;
        ProductFromMul = '0;
        @(negedge Clk);
        check("fi idle_hold", MulHoldFlagToMul, 2'b00);
        check("fi idle_stall", MulStallToCtrl, 1'b0);
        check("fi idle_wb", WbValid, 1'b0);
        run_op(0);

        // Flush and end together in WAIT.
        next_cycle();
        present_req(64'd6, 64'd6, 5'd8, OP, 3'b000);
        next_cycle();
        MulReqValid = 1'b0;
        next_cycle();
        Flush = 1'b1;
        MulHoldEndFromMul = 1'b1;
        ProductFromMul = 128'd36;
        next_cycle();
        Flush = 1'b0;
        MulHoldEndFromMul = 1'b0;
        ProductFromMul = '0;
        @(negedge Clk);
        check("fe wb", WbValid, 1'b0);
        check("fe hold", MulHoldFlagToMul, 2'b00);
        check("fe stall", MulStallToCtrl, 1'b0);
        next_cycle();
        @(negedge Clk);
        check("fe wb_late", WbValid, 1'b0);

        // Flush together with a request in IDLE: nothing is issued.
        next_cycle();
        present_req(64'd9, 64'd9, 5'd11, OP, 3'b000);
        Flush = 1'b1;
        @(negedge Clk);
        check("fr stall", MulStallToCtrl, 1'b0);
        next_cycle();
        MulReqValid = 1'b0;
        Flush = 1'b0;
        @(negedge Clk);
        check("fr hold", MulHoldFlagToMul, 2'b00);
        check("fr rd_not_captured", MulWriteAddrToMul, 5'd8);

        // Watchdog: no end for 64 WAIT cycles.
        next_cycle();
        present_req(64'd2, 64'd2, 5'd9, OP, 3'b000);
        next_cycle();
        MulReqValid = 1'b0;
        for (int k = 0; k < 64; k++) begin
            next_cycle();
            @(negedge Clk);
            check($sformatf("to busy%0d", k), {MulHoldFlagToMul, MulStallToCtrl, MulTimeout}, {2'b10, 1'b1, 1'b0});
        end
        next_cycle();
        @(negedge Clk);
        check("to flag", MulTimeout, 1'b1);
        check("to stall", MulStallToCtrl, 1'b0);
        check("to hold", MulHoldFlagToMul, 2'b00);
        check("to wb", WbValid, 1'b0);
        repeat (3) next_cycle();
        @(negedge Clk);
        check("to sticky", MulTimeout, 1'b1);

        // Asynchronous reset in the middle of WAIT.
        next_cycle();
        present_req(64'd8, 64'd8, 5'd4, OP, 3'b000);
        next_cycle();
        MulReqValid = 1'b0;
        repeat (2) next_cycle();
        #2;
        Rst = 1'b0;
        #1;
        check_all_zero("rst_mid");
        @(negedge Clk);
        Rst = 1'b1;
        run_op(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
